imu_sync_multi: RTL and testbench

Parametrised successor to the single-stream IMU synchroniser. It holds the latest two timestamped samples for each of NCH IMU channels. On a sync request it walks the channels in order and emits one time-aligned, linearly interpolated sample per channel at the requested instant. The block sits between the per-sensor timestamp capture and the fusion core, and replaces the fixed 64-bit, single-channel path with a variable lane count, lane width and channel count, plus valid/ready back-pressure.

---
 rtl/imu_sync_pkg.sv | 32 +++
 rtl/imu_sync_divider.sv | 72 +++++++
 rtl/imu_sync_multi.sv | 221 ++++++++++++++++++++++
 tb/tb_imu_sync_multi.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_sync_pkg.sv
// imu_sync_pkg: shared types and helpers for the multi-channel IMU synchroniser.
// FSM state encoding, output flag bit positions and lane saturation.
package imu_sync_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DIV,
      MUL,
      OUT
   } state_e;

   localparam int FLG_NODATA   = 0;
   localparam int FLG_CLAMP_LO = 1;
   localparam int FLG_CLAMP_HI = 2;
   localparam int FLG_STALE    = 3;

   // Clamp a signed value into the range of a w-bit two's complement lane.
   function automatic logic signed [63:0] sat_s(
      input logic signed [63:0] v,
      input int unsigned        w
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/imu_sync_divider.sv
// imu_sync_divider: serial restoring divider, one quotient bit per cycle.
// Requires num_i < den_i, so the FRAC_W-bit quotient is a pure fraction.
module imu_sync_divider #(
   parameter int TS_W   = 64,
   parameter int FRAC_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [TS_W-1:0]   num_i,
   input  logic [TS_W-1:0]   den_i,
   output logic              done_o,
   output logic [FRAC_W-1:0] quo_o
);

   localparam int CW = $clog2(FRAC_W + 1);

   logic [TS_W-1:0]   rem_q, rem_d;
   logic [TS_W-1:0]   den_q, den_d;
   logic [FRAC_W-1:0] quo_q, quo_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [TS_W:0]     shl;

   // One restoring step per cycle; done flags the cycle of the final step.
   always_comb begin
      rem_d  = rem_q;
      den_d  = den_q;
      quo_d  = quo_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      shl    = {rem_q, 1'b0};
      if (start_i) begin
         rem_d  = num_i;
         den_d  = den_i;
         quo_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (shl >= {1'b0, den_q}) begin
            rem_d = TS_W'(shl - {1'b0, den_q});
            quo_d = (quo_q << 1) | FRAC_W'(1);
         end else begin
            rem_d = shl[TS_W-1:0];
            quo_d = quo_q << 1;
         end
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(FRAC_W - 1)) busy_d = 1'b0;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= '0;
         den_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         den_q  <= den_d;
         quo_q  <= quo_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign done_o = busy_q && (cnt_q == CW'(FRAC_W - 1));
   assign quo_o  = quo_q;

endmodule

// File: rtl/imu_sync_multi.sv
// imu_sync_multi: per-channel 2-deep history, sweep-wise interpolation.
// Optional stale flag: define IMU_SYNC_STALE_CHECK_EN.
module imu_sync_multi
   import imu_sync_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int LANES  = 4,
   parameter int LANE_W = 16,
   parameter int TS_W   = 64,
   parameter int FRAC_W = 16
`ifdef IMU_SYNC_STALE_CHECK_EN
   ,
   parameter logic [TS_W-1:0] STALE_LIMIT = TS_W'(1000)
`endif
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NCH-1:0]                         in_valid,
   input  logic [NCH*LANES*LANE_W-1:0]            in_data,
   input  logic [NCH*TS_W-1:0]                    in_ts,
   input  logic                                   sync_req,
   input  logic [TS_W-1:0]                        sync_time,
   output logic                                   sync_busy,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [((NCH>1)?$clog2(NCH):1)-1:0]     out_ch,
   output logic [LANES*LANE_W-1:0]                out_data,
   output logic [3:0]                             out_flags,
   output logic                                   out_last
);

   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DW = LANES * LANE_W;
   localparam int PW = LANE_W + FRAC_W + 2;
   localparam int XW = LANE_W + 1;

   logic [DW-1:0]   hp_data_q [NCH];
   logic [DW-1:0]   hc_data_q [NCH];
   logic [TS_W-1:0] hp_ts_q   [NCH];
   logic [TS_W-1:0] hc_ts_q   [NCH];
   logic [1:0]      hcnt_q    [NCH];

   state_e          state_q, state_d;
   logic [CW-1:0]   ch_q, ch_d;
   logic [TS_W-1:0] st_q, st_d;
   logic [DW-1:0]   sp_q, sp_d, sc_q, sc_d;
   logic [DW-1:0]   od_q, od_d;
   logic [3:0]      fl_q, fl_d;

   logic [TS_W-1:0]   h_pts, h_cts, div_num, div_den;
   logic [1:0]        h_cnt;
   logic              stale, div_start, div_done;
   logic [FRAC_W-1:0] div_quo;
   logic [FRAC_W:0]   t_sel;
   logic [DW-1:0]     mul_res;
   logic signed [LANE_W-1:0] pv, cv;
   logic signed [XW-1:0]     df;
   logic signed [PW-1:0]     pr, sm;

   assign h_pts   = hp_ts_q[ch_q];
   assign h_cts   = hc_ts_q[ch_q];
   assign h_cnt   = hcnt_q[ch_q];
   assign div_num = st_q - h_pts;
   assign div_den = h_cts - h_pts;

`ifdef IMU_SYNC_STALE_CHECK_EN
   assign stale = (h_cnt != 2'd0) && (st_q > h_cts) &&
                  ((st_q - h_cts) > STALE_LIMIT);
`else
   assign stale = 1'b0;
`endif

   // Sample history: shift curr into prev on every strobe, count saturates at 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            hp_data_q[c] <= '0;
            hc_data_q[c] <= '0;
            hp_ts_q[c]   <= '0;
            hc_ts_q[c]   <= '0;
            hcnt_q[c]    <= '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (in_valid[c]) begin
               hp_data_q[c] <= hc_data_q[c];
               hc_data_q[c] <= in_data[c*DW +: DW];
               hp_ts_q[c]   <= hc_ts_q[c];
               hc_ts_q[c]   <= in_ts[c*TS_W +: TS_W];
               hcnt_q[c]    <= (hcnt_q[c] == 2'd2) ? 2'd2 : hcnt_q[c] + 2'd1;
            end
         end
      end
   end

   imu_sync_divider #(
      .TS_W   (TS_W),
      .FRAC_W (FRAC_W)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .start_i (div_start),
      .num_i   (div_num),
      .den_i   (div_den),
      .done_o  (div_done),
      .quo_o   (div_quo)
   );

   // Interpolation factor: clamp flags force 0 or 1.0, otherwise the quotient.
   always_comb begin
      t_sel = {1'b0, div_quo};
      if (fl_q[FLG_CLAMP_HI])      t_sel = {1'b1, {FRAC_W{1'b0}}};
      else if (fl_q[FLG_CLAMP_LO]) t_sel = '0;
   end

   // Per-lane prev + ((curr-prev)*t >>> FRAC_W), saturated to the lane width.
   always_comb begin
      mul_res = '0;
      pv = '0;
      cv = '0;
      df = '0;
      pr = '0;
      sm = '0;
      for (int l = 0; l < LANES; l++) begin
         pv = sp_q[l*LANE_W +: LANE_W];
         cv = sc_q[l*LANE_W +: LANE_W];
         df = XW'(cv) - XW'(pv);
         pr = PW'(df) * $signed(PW'(t_sel));
         sm = PW'(pv) + (pr >>> FRAC_W);
         mul_res[l*LANE_W +: LANE_W] = LANE_W'(sat_s(64'(sm), unsigned'(LANE_W)));
      end
   end

   // Sweep FSM: classify each channel, interpolate, hold until handshake.
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      st_d      = st_q;
      sp_d      = sp_q;
      sc_d      = sc_q;
      od_d      = od_q;
      fl_d      = fl_q;
      div_start = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sync_req) begin
               st_d    = sync_time;
               ch_d    = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            fl_d            = '0;
            fl_d[FLG_STALE] = stale;
            sp_d            = hp_data_q[ch_q];
            sc_d            = hc_data_q[ch_q];
            if (h_cnt != 2'd2) begin
               fl_d[FLG_NODATA] = 1'b1;
               od_d    = (h_cnt == 2'd0) ? '0 : hc_data_q[ch_q];
               state_d = OUT;
            end else if (st_q <= h_pts) begin
               fl_d[FLG_CLAMP_LO] = 1'b1;
               state_d = MUL;
            end else if (st_q >= h_cts || h_cts == h_pts) begin
               fl_d[FLG_CLAMP_HI] = 1'b1;
               state_d = MUL;
            end else begin
               div_start = 1'b1;
               state_d   = DIV;
            end
         end
         DIV: begin
            if (div_done) state_d = MUL;
         end
         MUL: begin
            od_d    = mul_res;
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) begin
               if (ch_q == CW'(NCH - 1)) begin
                  state_d = IDLE;
               end else begin
                  ch_d    = ch_q + CW'(1);
                  state_d = LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and output holding registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ch_q    <= '0;
         st_q    <= '0;
         sp_q    <= '0;
         sc_q    <= '0;
         od_q    <= '0;
         fl_q    <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         st_q    <= st_d;
         sp_q    <= sp_d;
         sc_q    <= sc_d;
         od_q    <= od_d;
         fl_q    <= fl_d;
      end
   end

   assign sync_busy = (state_q != IDLE);
   assign out_valid = (state_q == OUT);
   assign out_ch    = ch_q;
   assign out_data  = od_q;
   assign out_flags = fl_q;
   assign out_last  = (state_q == OUT) && (ch_q == CW'(NCH - 1));

endmodule

// File: tb/tb_imu_sync_multi.sv
// tb_imu_sync_multi: directed plus random sweeps against a reference model.
// Model tracks each channel's last two samples and interpolates arithmetically.
module tb_imu_sync_multi;

   localparam int NCH    = 4;
   localparam int LANES  = 4;
   localparam int LANE_W = 16;
   localparam int TS_W   = 64;
   localparam int FRAC_W = 16;
   localparam int DW     = LANES * LANE_W;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NCH-1:0]        in_valid;
   logic [NCH*DW-1:0]     in_data;
   logic [NCH*TS_W-1:0]   in_ts;
   logic                  sync_req;
   logic [TS_W-1:0]       sync_time;
   logic                  sync_busy;
   logic                  out_valid;
   logic                  out_ready;
   logic [1:0]            out_ch;
   logic [DW-1:0]         out_data;
   logic [3:0]            out_flags;
   logic                  out_last;

   int total = 0;
   int bad   = 0;

   longint      m_pts [NCH];
   longint      m_cts [NCH];
   logic [63:0] m_pd  [NCH];
   logic [63:0] m_cd  [NCH];
   int          m_cnt [NCH];

   always #5 clk = ~clk;

   imu_sync_multi dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ts     (in_ts),
      .sync_req  (sync_req),
      .sync_time (sync_time),
      .sync_busy (sync_busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_data  (out_data),
      .out_flags (out_flags),
      .out_last  (out_last)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rep(input int v);
      logic [15:0] h;
      h = v[15:0];
      return {4{h}};
   endfunction

   function automatic void mdl_clear();
      for (int c = 0; c < NCH; c++) begin
         m_pts[c] = 0;
         m_cts[c] = 0;
         m_pd[c]  = '0;
         m_cd[c]  = '0;
         m_cnt[c] = 0;
      end
   endfunction

   function automatic void mdl_wr(input int c, input longint ts,
                                  input logic [63:0] d);
      m_pts[c] = m_cts[c];
      m_pd[c]  = m_cd[c];
      m_cts[c] = ts;
      m_cd[c]  = d;
      if (m_cnt[c] < 2) m_cnt[c]++;
   endfunction

   // Expected output of channel c for a sync at st, plus expected latency.
   function automatic void expect_ch(input int c, input longint st,
                                     output logic [63:0] d,
                                     output logic [3:0] f,
                                     output int lat);
      longint t, p, q, a, fl, v;
      d = '0;
      f = '0;
`ifdef IMU_SYNC_STALE_CHECK_EN
      if (m_cnt[c] != 0 && st > m_cts[c] && st - m_cts[c] > 1000) f[3] = 1'b1;
`endif
      if (m_cnt[c] < 2) begin
         f[0] = 1'b1;
         d    = (m_cnt[c] == 0) ? 64'd0 : m_cd[c];
         lat  = 1;
      end else if (st <= m_pts[c]) begin
         f[1] = 1'b1;
         d    = m_pd[c];
         lat  = 2;
      end else if (st >= m_cts[c] || m_cts[c] == m_pts[c]) begin
         f[2] = 1'b1;
         d    = m_cd[c];
         lat  = 2;
      end else begin
         t = ((st - m_pts[c]) * 65536) / (m_cts[c] - m_pts[c]);
         for (int l = 0; l < LANES; l++) begin
            p  = longint'($signed(m_pd[c][l*16 +: 16]));
            q  = longint'($signed(m_cd[c][l*16 +: 16]));
            a  = (q - p) * t;
            fl = a / 65536;
            if (a < 0 && (a % 65536) != 0) fl = fl - 1;
            v  = p + fl;
            if (v > 32767)  v = 32767;
            if (v < -32768) v = -32768;
            d[l*16 +: 16] = v[15:0];
         end
         lat = FRAC_W + 2;
      end
   endfunction

   task automatic wr(input int c, input longint ts, input logic [63:0] d);
      @(negedge clk);
      in_valid               = '0;
      in_valid[c]            = 1'b1;
      in_data[c*DW +: DW]    = d;
      in_ts[c*TS_W +: TS_W]  = TS_W'(ts);
      @(negedge clk);
      in_valid = '0;
      mdl_wr(c, ts, d);
   endtask

   // One full sweep; channel hc is held for hn cycles with a write mid-hold.
   task automatic sweep(input longint st, input int hc, input int hn);
      logic [63:0] ed, nd;
      logic [3:0]  ef;
      int          el, k, n;
      longint      nts;
      @(negedge clk);
      sync_req  = 1'b1;
      sync_time = TS_W'(st);
      @(negedge clk);
      sync_req = 1'b0;
      chk("busy_acc", 64'(sync_busy), 64'd1);
      for (int c = 0; c < NCH; c++) begin
         expect_ch(c, st, ed, ef, el);
         k = 0;
         while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
         end
         chk("valid", 64'(out_valid), 64'd1);
         chk("latency", 64'(k), 64'(el));
         chk("out_ch", 64'(out_ch), 64'(c));
         chk("data", out_data, ed);
         chk("flags", 64'(out_flags), 64'(ef));
         chk("last", 64'(out_last), 64'(c == NCH - 1));
         n = (c == hc) ? hn : $urandom_range(0, 2);
         for (int i = 0; i < n; i++) begin
            if (c == hc && i == 0) sync_req = 1'b1;
            if (c == hc && i == 2) begin
               nd  = {$urandom, $urandom};
               nts = longint'($urandom_range(0, 2000));
               in_valid              = '0;
               in_valid[c]           = 1'b1;
               in_data[c*DW +: DW]   = nd;
               in_ts[c*TS_W +: TS_W] = TS_W'(nts);
               mdl_wr(c, nts, nd);
            end
            @(negedge clk);
            sync_req = 1'b0;
            in_valid = '0;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, ed);
            chk("hold_flags", 64'(out_flags), 64'(ef));
         end
         out_ready = 1'b1;
         sync_req  = (c == NCH - 1);
         @(negedge clk);
         out_ready = 1'b0;
         sync_req  = 1'b0;
      end
      chk("busy_end", 64'(sync_busy), 64'd0);
      chk("valid_end", 64'(out_valid), 64'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      in_ts     = '0;
      sync_req  = 1'b0;
      sync_time = '0;
      out_ready = 1'b0;
      mdl_clear();
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(sync_busy), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_flags", 64'(out_flags), 64'd0);
      chk("rst_ch", 64'(out_ch), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      rst = 1'b0;

      wr(0, 100, rep(0));
      wr(0, 200, rep(1000));
      sweep(150, -1, 0);

      wr(0, 100, rep(-200));
      wr(0, 200, rep(400));
      sweep(50, -1, 0);
      sweep(250, -1, 0);
      wr(0, 200, rep(700));
      sweep(300, -1, 0);

      wr(2, 100, rep(-5000));
      wr(2, 300, rep(9000));
      sweep(220, 2, 10);

      wr(1, 0, rep(-32768));
      wr(1, 65536, rep(32767));
      sweep(65535, -1, 0);
      wr(1, 65536, {16'h8000, 16'h7fff, 16'h8000, 16'h7fff});
      wr(1, 131071, {16'h7fff, 16'h8000, 16'h0001, 16'hffff});
      sweep(131070, -1, 0);

      for (int it = 0; it < 25; it++) begin
         int nw;
         nw = $urandom_range(0, 4);
         for (int w = 0; w < nw; w++)
            wr($urandom_range(0, NCH - 1), longint'($urandom_range(0, 2000)),
               {$urandom, $urandom});
         sweep(longint'($urandom_range(0, 2100)),
               $urandom_range(0, NCH), $urandom_range(0, 5));
      end

      wr(0, 0, rep(0));
      wr(0, 100, rep(1000));
      @(negedge clk);
      sync_req  = 1'b1;
      sync_time = 64'd50;
      @(negedge clk);
      sync_req = 1'b0;
      repeat (4) @(negedge clk);
      chk("div_busy", 64'(sync_busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", 64'(sync_busy), 64'd0);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_data", out_data, 64'd0);
      chk("mid_rst_flags", 64'(out_flags), 64'd0);
      chk("mid_rst_last", 64'(out_last), 64'd0);
      rst = 1'b0;
      mdl_clear();
      repeat (3) @(negedge clk);
      chk("post_rst_valid", 64'(out_valid), 64'd0);
      sweep(100, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
